// File: rtl/uart_tx_drain.sv
// rtl/uart_tx_drain.sv - UART transmitter that drains a show-ahead byte FIFO onto the tx pin.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1); default frame is 8N1.
module uart_tx_drain #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163,
  parameter int DVSR_W  = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_r_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int TW = ($clog2(SB_TICK + 1) > 5) ? $clog2(SB_TICK + 1) : 5;
  localparam int NW = $clog2(DBIT + 1);
  localparam logic [TW-1:0]     LAST_BIT_TICK  = TW'(15);
  localparam logic [TW-1:0]     LAST_STOP_TICK = TW'(SB_TICK - 1);
  localparam logic [NW-1:0]     LAST_DATA_BIT  = NW'(DBIT - 1);
  localparam logic [DVSR_W-1:0] DIV_LAST       = DVSR_W'(DVSR - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
`ifdef UART_TX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t            state_q;
  logic [DVSR_W-1:0] div_q;
  logic [TW-1:0]     tick_q;
  logic [NW-1:0]     bit_q;
  logic [DBIT-1:0]   shift_q;
  logic              tx_q;
  logic              s_tick;
  logic              start_frame;
`ifdef UART_TX_PARITY_EN
  logic              par_q;
`endif

  assign s_tick       = (div_q == DIV_LAST);
  assign start_frame  = (state_q == IDLE) & ~fifo_empty;
  // Gated by reset_n so a held reset never pops a queued word.
  assign fifo_rd      = reset_n & start_frame;
  assign tx           = tx_q;
  assign tx_busy      = (state_q != IDLE);
  assign tx_done_tick = (state_q == STOP) & s_tick & (tick_q == LAST_STOP_TICK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      // Restarting the divider at the pop makes every bit exactly 16*DVSR clocks.
      div_q <= (start_frame || s_tick) ? '0 : div_q + DVSR_W'(1);
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (start_frame) begin
            shift_q <= fifo_r_data;
            tx_q    <= 1'b0;
            tick_q  <= '0;
            state_q <= START;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^fifo_r_data;
`endif
          end
        end
        START: begin
          if (s_tick) begin
            if (tick_q == LAST_BIT_TICK) begin
              tick_q  <= '0;
              bit_q   <= '0;
              tx_q    <= shift_q[0];
              state_q <= DATA;
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (tick_q == LAST_BIT_TICK) begin
              tick_q <= '0;
              if (bit_q == LAST_DATA_BIT) begin
`ifdef UART_TX_PARITY_EN
                tx_q    <= par_q;
                state_q <= PARITY;
`else
                tx_q    <= 1'b1;
                state_q <= STOP;
`endif
              end else begin
                shift_q <= shift_q >> 1;
                tx_q    <= shift_q[1];
                bit_q   <= bit_q + NW'(1);
              end
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (tick_q == LAST_BIT_TICK) begin
              tick_q  <= '0;
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
`endif
        STOP: begin
          tx_q <= 1'b1;
          if (s_tick) begin
            if (tick_q == LAST_STOP_TICK) begin
              tick_q  <= '0;
              state_q <= IDLE;
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
